// File: rtl/mic1_ctrl_pkg.sv
// rtl/mic1_ctrl_pkg.sv - shared types and constants for the MIC-1 execution controller
package mic1_ctrl_pkg;

  localparam int EXEC_STATE_W            = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 60000;

  typedef enum logic [EXEC_STATE_W-1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } exec_state_t;

endpackage

// File: rtl/mic1_debounce.sv
// rtl/mic1_debounce.sv - button synchroniser, debouncer and rising-edge press detector
module mic1_debounce
  import mic1_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_ff1;
  logic          sync_ff2;
  logic          level_q;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser for the asynchronous pad input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
    end else begin
      sync_ff1 <= btn;
      sync_ff2 <= sync_ff1;
    end
  end

  // Accept a new level only after it has been stable for DEBOUNCE_CYCLES; any bounce restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_ff2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt   <= '0;
      level <= sync_ff2;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Delayed copy of the accepted level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  // Only presses matter; releases produce no pulse.
  assign press = level & ~level_q;

endmodule

// File: rtl/mic1_exec_ctrl.sv
// rtl/mic1_exec_ctrl.sv - run/step/stop execution controller producing the MIC-1 clock-enable
module mic1_exec_ctrl
  import mic1_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit STEP_MACRO      = 1'b1,
  parameter int CNT_W           = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_run,
  input  logic                    btn_step,
  input  logic                    btn_stop,
  input  logic                    instr_boundary,
  input  logic                    cpu_halt,
  output logic                    cpu_en,
  output logic [EXEC_STATE_W-1:0] state,
  output logic                    step_done,
  output logic                    led_run,
  output logic                    led_halt,
  output logic [CNT_W-1:0]        instr_count
);

  exec_state_t state_q, state_n;
  logic        pause_pending, pause_n;
  logic        step_exec, exec_n;
  logic        press_run, press_step, press_stop;
  logic        run_p, step_p;
  logic        step_stop;
  logic [2:0]  unused_btn_level;

  mic1_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk(clk), .rst(rst), .btn(btn_run),  .level(unused_btn_level[0]), .press(press_run)
  );
  mic1_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk(clk), .rst(rst), .btn(btn_step), .level(unused_btn_level[1]), .press(press_step)
  );
  mic1_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
    .clk(clk), .rst(rst), .btn(btn_stop), .level(unused_btn_level[2]), .press(press_stop)
  );

  // Coincident presses resolve stop > step > run; losers are dropped.
  assign step_p = press_step & ~press_stop;
  assign run_p  = press_run & ~press_step & ~press_stop;

  // A step ends once something has executed and, in macro mode, the CPU is back at Main1.
  assign step_stop = (state_q == STEP) && step_exec && (instr_boundary || !STEP_MACRO);

  assign cpu_en   = ((state_q == RUN) || (state_q == STEP))
                  && !(pause_pending && instr_boundary) && !step_stop;
  assign state    = state_q;
  assign led_run  = (state_q == RUN) || (state_q == STEP);
  assign led_halt = (state_q == HALTED);

  // Controller state, pending pause request and step-progress flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pause_pending <= 1'b0;
      step_exec     <= 1'b0;
    end else begin
      state_q       <= state_n;
      pause_pending <= pause_n;
      step_exec     <= exec_n;
    end
  end

  // Next-state logic; a halt seen while enabled overrides every other transition.
  always_comb begin
    state_n   = state_q;
    pause_n   = pause_pending;
    exec_n    = step_exec;
    step_done = 1'b0;
    case (state_q)
      IDLE: begin
        pause_n = 1'b0;
        exec_n  = 1'b0;
        if (run_p)       state_n = RUN;
        else if (step_p) state_n = STEP;
      end
      RUN: begin
        if (pause_pending && instr_boundary) begin
          state_n = IDLE;
          pause_n = 1'b0;
        end else if (press_stop) begin
          pause_n = 1'b1;
        end
      end
      STEP: begin
        if (cpu_en) exec_n = 1'b1;
        if (step_stop || (pause_pending && instr_boundary)) begin
          state_n   = IDLE;
          pause_n   = 1'b0;
          exec_n    = 1'b0;
          step_done = step_stop && !pause_pending;
        end else if (press_stop && STEP_MACRO) begin
          // A microstep is a single cycle and always completes, so only macro steps can be aborted.
          pause_n = 1'b1;
        end
      end
      HALTED: begin
        state_n = HALTED;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (cpu_halt && cpu_en) begin
      state_n = HALTED;
      pause_n = 1'b0;
      exec_n  = 1'b0;
    end
  end

  // Count macroinstructions as they start; survives IDLE, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           instr_count <= '0;
    else if (instr_boundary && cpu_en) instr_count <= instr_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_mic1_exec_ctrl.sv
// tb/tb_mic1_exec_ctrl.sv - self-checking bench for mic1_exec_ctrl
module tb_mic1_exec_ctrl;
  import mic1_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_run = 1'b0, btn_step = 1'b0, btn_stop = 1'b0;
  logic        cpu_halt = 1'b0;
  logic        instr_boundary;
  logic        cpu_en, step_done, led_run, led_halt;
  logic [1:0]  state;
  logic [31:0] instr_count;

  logic        btn_step0 = 1'b0;
  logic        ib0 = 1'b0;
  logic        zero = 1'b0;
  logic        cpu_en0, step_done0, led_run0, led_halt0;
  logic [1:0]  state0;
  logic [7:0]  instr_count0;

  logic [2:0]  phase;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       run, step, stop;
    logic [1:0] st;
    logic       en, lr;
  } vec_t;

  typedef struct {
    int         idx;
    logic [1:0] st;
    logic       en, lr;
  } exp_t;

  vec_t vecs [8];
  exp_t sb [$];

  always #5 clk = ~clk;

  mic1_exec_ctrl #(.DEBOUNCE_CYCLES(4), .STEP_MACRO(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step), .btn_stop(btn_stop),
    .instr_boundary(instr_boundary), .cpu_halt(cpu_halt), .cpu_en(cpu_en), .state(state),
    .step_done(step_done), .led_run(led_run), .led_halt(led_halt), .instr_count(instr_count)
  );

  mic1_exec_ctrl #(.DEBOUNCE_CYCLES(4), .STEP_MACRO(1'b0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .btn_run(zero), .btn_step(btn_step0), .btn_stop(zero),
    .instr_boundary(ib0), .cpu_halt(zero), .cpu_en(cpu_en0), .state(state0),
    .step_done(step_done0), .led_run(led_run0), .led_halt(led_halt0), .instr_count(instr_count0)
  );

  // Stub CPU: every 5th enabled cycle begins a new macroinstruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         phase <= 3'd0;
    else if (cpu_en) phase <= (phase == 3'd4) ? 3'd0 : phase + 3'd1;
  end
  assign instr_boundary = (phase == 3'd0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn_run = 1'b0; btn_step = 1'b0; btn_stop = 1'b0; cpu_halt = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    bit         seen;
    logic [31:0] c0;
    exp_t       e;

    vecs[0] = '{1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, RUN,  1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, STEP, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, IDLE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, IDLE, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, STEP, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, IDLE, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, IDLE, 1'b0, 1'b0};

    // Reset values.
    tick(2);
    chk("rst_state", state, IDLE);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_step_done", step_done, 0);
    chk("rst_led_run", led_run, 0);
    chk("rst_led_halt", led_halt, 0);
    chk("rst_count", instr_count, 0);
    rst = 1'b0;

    // Run press: pulse 6 cycles after the raw edge, RUN from the following cycle.
    btn_run = 1'b1;
    tick(6);
    chk("run_not_yet", state, IDLE);
    tick(1);
    chk("run_state", state, RUN);
    chk("run_cpu_en", cpu_en, 1);
    chk("run_led", led_run, 1);
    tick(13);
    btn_run = 1'b0;
    tick(37);
    chk("run_count50", instr_count, 10);

    // Short stop pulse and a glitch are filtered out.
    btn_stop = 1'b1; tick(3);
    btn_stop = 1'b0; tick(2);
    btn_stop = 1'b1; tick(1);
    btn_stop = 1'b0; tick(12);
    chk("glitch_still_run", state, RUN);

    // Held stop: pause lands exactly on the next boundary cycle.
    btn_stop = 1'b1;
    tick(7);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (instr_boundary) begin
        seen = 1'b1;
        chk("pause_cpu_en", cpu_en, 0);
        chk("pause_state_run", state, RUN);
      end else begin
        chk("pre_pause_cpu_en", cpu_en, 1);
        tick(1);
      end
    end
    if (!seen) chk("pause_timeout", 0, 1);
    c0 = instr_count;
    tick(1);
    chk("pause_idle", state, IDLE);
    tick(3);
    btn_stop = 1'b0;
    tick(20);
    chk("pause_count_frozen", instr_count, c0);
    chk("pause_cpu_en_low", cpu_en, 0);

    // Macro step from IDLE at a boundary.
    c0 = instr_count;
    btn_step = 1'b1;
    tick(7);
    chk("step_state", state, STEP);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (cpu_en) begin
        n++;
        tick(1);
      end else begin
        seen = 1'b1;
        chk("step_done_pulse", step_done, 1);
        chk("step_en_cycles", n, 5);
      end
    end
    if (!seen) chk("step_timeout", 0, 1);
    tick(1);
    chk("step_done_clear", step_done, 0);
    chk("step_idle", state, IDLE);
    chk("step_count", instr_count, c0 + 32'd1);
    btn_step = 1'b0;

    // Micro step build: one enabled cycle, then step_done.
    btn_step0 = 1'b1;
    tick(7);
    chk("ustep_state", state0, STEP);
    chk("ustep_en", cpu_en0, 1);
    chk("ustep_done_early", step_done0, 0);
    tick(1);
    chk("ustep_en_off", cpu_en0, 0);
    chk("ustep_done", step_done0, 1);
    tick(1);
    chk("ustep_done_clear", step_done0, 0);
    chk("ustep_idle", state0, IDLE);
    btn_step0 = 1'b0;

    // Simultaneous raw edges from IDLE: priority table through the scoreboard.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      btn_run  = vecs[i].run;
      btn_step = vecs[i].step;
      btn_stop = vecs[i].stop;
      sb.push_back('{i, vecs[i].st, vecs[i].en, vecs[i].lr});
      tick(7);
      if (sb.size() == 0) begin
        chk("sb_empty", 0, 1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("vec%0d_state", e.idx), state, e.st);
        chk($sformatf("vec%0d_cpu_en", e.idx), cpu_en, e.en);
        chk($sformatf("vec%0d_led_run", e.idx), led_run, e.lr);
      end
      btn_run = 1'b0; btn_step = 1'b0; btn_stop = 1'b0;
    end

    // Halt while running is sticky against further presses.
    do_reset();
    btn_run = 1'b1;
    tick(7);
    chk("halt_pre_run", state, RUN);
    btn_run = 1'b0;
    tick(3);
    cpu_halt = 1'b1;
    tick(1);
    cpu_halt = 1'b0;
    chk("halt_state", state, HALTED);
    chk("halt_led", led_halt, 1);
    chk("halt_cpu_en", cpu_en, 0);
    chk("halt_led_run", led_run, 0);
    btn_run = 1'b1; tick(8); btn_run = 1'b0;
    btn_step = 1'b1; tick(8); btn_step = 1'b0;
    tick(4);
    chk("halt_sticky", state, HALTED);

    // Asynchronous reset in the middle of a run cycle.
    do_reset();
    btn_run = 1'b1;
    tick(7);
    chk("arst_pre_run", state, RUN);
    btn_run = 1'b0;
    tick(3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_cpu_en", cpu_en, 0);
    chk("arst_state", state, IDLE);
    chk("arst_led_run", led_run, 0);
    chk("arst_led_halt", led_halt, 0);
    chk("arst_step_done", step_done, 0);
    chk("arst_count", instr_count, 0);
    tick(2);
    rst = 1'b0;
    btn_run = 1'b1;
    tick(7);
    chk("arst_rerun_state", state, RUN);
    chk("arst_rerun_en", cpu_en, 1);
    btn_run = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
